// File: rtl/sobel_pkg.sv
// Shared encodings for the Sobel stream engine: filter modes, FSM states, pipeline depth.
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_MOVE = 2'd0,
    MODE_MAG  = 2'd1,
    MODE_BIN  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int unsigned PIPE_LAT = 4;

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-row line buffer: tap_r1 holds the previous row, tap_r2 the row before it, at column idx.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_WIDTH  = 256,
  parameter int unsigned IDX_W      = $clog2(MAX_WIDTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] tap_r1,
  output logic [DATA_WIDTH-1:0] tap_r2
);

  logic [DATA_WIDTH-1:0] row1 [MAX_WIDTH];
  logic [DATA_WIDTH-1:0] row2 [MAX_WIDTH];

  assign tap_r1 = row1[idx];
  assign tap_r2 = row2[idx];

  // Same column read-then-write: the older row ages into row2 as the new pixel lands in row1.
  always_ff @(posedge clk) begin
    if (we) begin
      row1[idx] <= din;
      row2[idx] <= row1[idx];
    end
  end

endmodule

// File: rtl/sobel_stream_engine.sv
// BRAM0 -> BRAM1 raster-order 3x3 filter engine: MOVE copy, saturated Sobel magnitude or binary edge map.
module sobel_stream_engine
  import sobel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MAX_WIDTH  = 256,
  parameter int unsigned MAX_HEIGHT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [1:0]            i_mode,
  input  logic [ADDR_WIDTH-1:0] i_width,
  input  logic [ADDR_WIDTH-1:0] i_height,
  input  logic [DATA_WIDTH-1:0] i_thresh,
  output logic                  b0_ce,
  output logic [ADDR_WIDTH-1:0] b0_addr,
  input  logic [DATA_WIDTH-1:0] b0_q,
  output logic                  b1_ce,
  output logic                  b1_we,
  output logic [ADDR_WIDTH-1:0] b1_addr,
  output logic [DATA_WIDTH-1:0] b1_d,
  output logic                  o_idle,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int unsigned IDX_W = $clog2(MAX_WIDTH);
  localparam int unsigned GW    = DATA_WIDTH + 3;
  localparam int unsigned MW    = DATA_WIDTH + 4;

  state_t                state, state_nx;
  mode_t                 mode_q;
  logic [ADDR_WIDTH-1:0] w_q, h_q, col, row;
  logic [DATA_WIDTH-1:0] thr_q;
  logic [1:0]            drain_cnt;
  logic                  cfg_ok, start_ok, last_rd, kill;

  assign cfg_ok = (i_mode != MODE_RSVD)
               && (i_width  >= ADDR_WIDTH'(3)) && (i_width  <= ADDR_WIDTH'(MAX_WIDTH))
               && (i_height >= ADDR_WIDTH'(3)) && (i_height <= ADDR_WIDTH'(MAX_HEIGHT));
  assign start_ok = (state == ST_IDLE) && i_start && cfg_ok;
  assign last_rd  = (col == w_q - 1'b1) && (row == h_q - 1'b1);
  assign kill     = i_abort && o_busy;

  assign b0_ce  = (state == ST_READ);
  assign o_idle = (state == ST_IDLE);
  assign o_busy = (state == ST_READ) || (state == ST_DRAIN);
  assign o_done = (state == ST_DONE);
  assign b1_ce  = b1_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start_ok) state_nx = ST_READ;
      ST_READ:  if (i_abort) state_nx = ST_IDLE;
                else if (last_rd) state_nx = ST_DRAIN;
      ST_DRAIN: if (i_abort) state_nx = ST_IDLE;
                else if (drain_cnt == 2'(PIPE_LAT - 1)) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= MODE_MOVE;
      w_q       <= '0;
      h_q       <= '0;
      thr_q     <= '0;
      col       <= '0;
      row       <= '0;
      b0_addr   <= '0;
      drain_cnt <= '0;
      o_err     <= 1'b0;
    end else begin
      o_err     <= (state == ST_IDLE) && i_start && !cfg_ok;
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
      if (start_ok) begin
        mode_q  <= mode_t'(i_mode);
        w_q     <= i_width;
        h_q     <= i_height;
        thr_q   <= i_thresh;
        col     <= '0;
        row     <= '0;
        b0_addr <= '0;
      end else if (state == ST_READ) begin
        if (last_rd) begin
          b0_addr <= '0;
          col     <= '0;
          row     <= '0;
        end else begin
          b0_addr <= b0_addr + 1'b1;
          if (col == w_q - 1'b1) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
    end
  end

  // Pipeline: s1 = read data returning, s2 = window shifted, s3 = kernel result, b1_* = write.
  logic                  s1_v, s2_v, s3_v, s2_take;
  logic [ADDR_WIDTH-1:0] s1_col, s1_row, s1_addr, s2_col, s2_row, s2_addr, s3_addr, out_cnt;
  logic [DATA_WIDTH-1:0] s3_d, lb_r1, lb_r2, res_d;
  logic [DATA_WIDTH-1:0] win [9];

  sobel_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_WIDTH  (MAX_WIDTH),
    .IDX_W      (IDX_W)
  ) u_line_buffer (
    .clk    (clk),
    .we     (s1_v),
    .idx    (s1_col[IDX_W-1:0]),
    .din    (b0_q),
    .tap_r1 (lb_r1),
    .tap_r2 (lb_r2)
  );

  logic [GW-1:0] gx, gy, ax, ay;
  logic [MW-1:0] mag;
  logic [DATA_WIDTH-1:0] sat;

  // Operands are zero-extended; the GW-bit wrap-around difference is the signed gradient.
  always_comb begin
    gx  = (GW'(win[2]) + (GW'(win[5]) << 1) + GW'(win[8]))
        - (GW'(win[0]) + (GW'(win[3]) << 1) + GW'(win[6]));
    gy  = (GW'(win[6]) + (GW'(win[7]) << 1) + GW'(win[8]))
        - (GW'(win[0]) + (GW'(win[1]) << 1) + GW'(win[2]));
    ax  = gx[GW-1] ? (~gx + 1'b1) : gx;
    ay  = gy[GW-1] ? (~gy + 1'b1) : gy;
    mag = MW'(ax) + MW'(ay);
    sat = (|mag[MW-1:DATA_WIDTH]) ? '1 : mag[DATA_WIDTH-1:0];
    unique case (mode_q)
      MODE_MOVE: res_d = win[8];
      MODE_BIN:  res_d = (sat >= thr_q) ? '1 : '0;
      default:   res_d = sat;
    endcase
    s2_take = !kill && s2_v
           && ((mode_q == MODE_MOVE) || ((s2_row >= ADDR_WIDTH'(2)) && (s2_col >= ADDR_WIDTH'(2))));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      s3_v    <= 1'b0;
      b1_we   <= 1'b0;
      s1_col  <= '0;
      s1_row  <= '0;
      s1_addr <= '0;
      s2_col  <= '0;
      s2_row  <= '0;
      s2_addr <= '0;
      s3_addr <= '0;
      s3_d    <= '0;
      out_cnt <= '0;
      b1_addr <= '0;
      b1_d    <= '0;
      for (int unsigned i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      s1_v    <= !kill && (state == ST_READ);
      s1_col  <= col;
      s1_row  <= row;
      s1_addr <= b0_addr;
      s2_v    <= !kill && s1_v;
      s2_col  <= s1_col;
      s2_row  <= s1_row;
      s2_addr <= s1_addr;
      if (s1_v) begin
        win[0] <= win[1]; win[1] <= win[2]; win[2] <= lb_r2;
        win[3] <= win[4]; win[4] <= win[5]; win[5] <= lb_r1;
        win[6] <= win[7]; win[7] <= win[8]; win[8] <= b0_q;
      end
      s3_v    <= s2_take;
      s3_d    <= res_d;
      s3_addr <= (mode_q == MODE_MOVE) ? s2_addr : out_cnt;
      if (start_ok)                              out_cnt <= '0;
      else if (s2_take && mode_q != MODE_MOVE)   out_cnt <= out_cnt + 1'b1;
      b1_we   <= !kill && s3_v;
      b1_addr <= s3_addr;
      b1_d    <= s3_d;
    end
  end

endmodule

// File: tb/tb_sobel_stream_engine.sv
// Scoreboard bench for sobel_stream_engine: directed frames with hand-computed BRAM1 writes.
module tb_sobel_stream_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0, i_abort = 1'b0;
  logic [1:0]  i_mode = '0;
  logic [15:0] i_width = '0, i_height = '0;
  logic [7:0]  i_thresh = '0;
  logic        b0_ce, b1_ce, b1_we;
  logic [15:0] b0_addr, b1_addr;
  logic [7:0]  b0_q = '0, b1_d;
  logic        o_idle, o_busy, o_done, o_err;

  sobel_stream_engine #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (16),
    .MAX_WIDTH  (256),
    .MAX_HEIGHT (256)
  ) dut (
    .clk (clk), .rst (rst), .i_start (i_start), .i_abort (i_abort), .i_mode (i_mode),
    .i_width (i_width), .i_height (i_height), .i_thresh (i_thresh),
    .b0_ce (b0_ce), .b0_addr (b0_addr), .b0_q (b0_q),
    .b1_ce (b1_ce), .b1_we (b1_we), .b1_addr (b1_addr), .b1_d (b1_d),
    .o_idle (o_idle), .o_busy (o_busy), .o_done (o_done), .o_err (o_err)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [4096];
  always @(posedge clk) if (b0_ce) b0_q <= mem[b0_addr[11:0]];

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];
  int  n_cmp = 0, n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every BRAM1 write is popped against the scoreboard.
  always @(negedge clk) begin
    if (!rst && (b1_we === 1'b1 || b1_ce === 1'b1)) begin
      chk("ce_we_pair", {30'd0, b1_ce, b1_we}, 32'd3);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", b1_addr, b1_d);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(b1_addr), 32'(e.a));
        chk("wr_data", 32'(b1_d), 32'(e.d));
      end
    end
  end

  task automatic push(input int a, input int d);
    exp_q.push_back({16'(a), 8'(d)});
  endtask

  task automatic start_frame(input int mode, input int w, input int h, input int thr);
    @(negedge clk);
    i_mode = 2'(mode); i_width = 16'(w); i_height = 16'(h); i_thresh = 8'(thr);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic run(input string name, input int mode, input int w, input int h, input int thr,
                     output int cyc);
    start_frame(mode, w, h, thr);
    cyc = 1;
    while (o_done !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_done"}, 32'(o_done), 32'd1);
    @(negedge clk);
    chk({name, "_done_pulse"}, {30'd0, o_done, o_idle}, 32'd1);
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reject(input string name, input int mode, input int w, input int h);
    start_frame(mode, w, h, 0);
    chk({name, "_err"}, {29'd0, o_err, o_idle, b0_ce}, 32'b110);
    @(negedge clk);
    chk({name, "_err_clr"}, {28'd0, o_err, o_idle, o_busy, b0_ce}, 32'b0100);
  endtask

  task automatic load_3x3(input bit descending);
    for (int k = 0; k < 9; k++) mem[k] = descending ? 8'(9 - k) : 8'(k + 1);
  endtask

  task automatic load_lr4();
    for (int k = 0; k < 16; k++) mem[k] = ((k % 4) < 2) ? 8'd0 : 8'd255;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n;
    bit saw;
    repeat (3) @(negedge clk);
    chk("rst_status", {28'd0, o_idle, o_busy, o_done, o_err}, 32'b1000);
    chk("rst_b0", {15'd0, b0_ce, b0_addr}, 32'd0);
    chk("rst_b1", {6'd0, b1_ce, b1_we, b1_addr, b1_d}, 32'd0);
    rst = 1'b0;

    // MOVE 4x4 ramp, done latency
    for (int k = 0; k < 16; k++) begin mem[k] = 8'(k); push(k, k); end
    run("move4", 0, 4, 4, 0, cyc);
    chk("move4_done_cycle", 32'(cyc), 32'd21);

    // MAG 5x5 constant: flat field gives zero gradient
    for (int k = 0; k < 25; k++) mem[k] = 8'd50;
    for (int k = 0; k < 9; k++) push(k, 0);
    run("mag5_flat", 1, 5, 5, 0, cyc);

    // MAG 5x5 ramp mem[k]=k: gx=8, gy=40 everywhere -> 48; checks row wrap
    for (int k = 0; k < 25; k++) mem[k] = 8'(k);
    for (int k = 0; k < 9; k++) push(k, 48);
    run("mag5_ramp", 1, 5, 5, 0, cyc);

    // MAG/BIN 4x4 vertical edge: gx=1020 saturates
    load_lr4();
    for (int k = 0; k < 4; k++) push(k, 255);
    run("mag4_edge", 1, 4, 4, 0, cyc);
    for (int k = 0; k < 4; k++) push(k, 255);
    run("bin4_edge", 2, 4, 4, 128, cyc);

    // 3x3 1..9: gx=8, gy=24, mag=32; descending gives negative gradients, same magnitude
    load_3x3(1'b0);
    push(0, 32);
    run("mag3_up", 1, 3, 3, 0, cyc);
    push(0, 255);
    run("bin3_eq", 2, 3, 3, 32, cyc);
    push(0, 0);
    run("bin3_above", 2, 3, 3, 33, cyc);
    load_3x3(1'b1);
    push(0, 32);
    run("mag3_down", 1, 3, 3, 0, cyc);

    // Rejected starts
    reject("rej_w2", 0, 2, 4);
    reject("rej_mode3", 3, 4, 4);
    reject("rej_h2", 1, 4, 2);
    reject("rej_w257", 1, 257, 4);

    // Abort while reading address 7 of 8x8 MOVE: only writes for addr 0..3 escape
    for (int k = 0; k < 64; k++) mem[k] = 8'((k * 7 + 3) & 255);
    for (int k = 0; k < 4; k++) push(k, (k * 7 + 3) & 255);
    start_frame(0, 8, 8, 0);
    n = 0;
    while (!(b0_ce === 1'b1 && b0_addr == 16'd7) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_addr7", 32'(b0_addr), 32'd7);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("abort_idle", {29'd0, o_idle, o_busy, b1_we}, 32'b100);
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      saw |= o_done;
    end
    chk("abort_no_done", 32'(saw), 32'd0);
    chk("abort_pending", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < 64; k++) push(k, (k * 7 + 3) & 255);
    run("restart8", 0, 8, 8, 0, cyc);

    // Async reset in first DRAIN cycle of 4x4 MAG: writes at addr 2,3 never happen
    load_lr4();
    push(0, 255);
    push(1, 255);
    start_frame(1, 4, 4, 0);
    n = 0;
    while (!(o_busy === 1'b1 && b0_ce === 1'b0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_drain_reached", {30'd0, o_busy, b0_ce}, 32'b10);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_status", {28'd0, o_idle, o_busy, o_done, o_err}, 32'b1000);
    chk("rst_async_b0", {15'd0, b0_ce, b0_addr}, 32'd0);
    chk("rst_async_b1", {6'd0, b1_ce, b1_we, b1_addr, b1_d}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_async_pending", 32'(exp_q.size()), 32'd0);
    load_3x3(1'b0);
    push(0, 32);
    run("fresh3", 1, 3, 3, 0, cyc);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
